// File: rtl/canon_sequencer.sv
// Tempo divider and ground-bass sequencer: emits beat/phrase strobes and the
// current canon bass note (MIDI number) with a load strobe for the synthesiser.
module canon_sequencer #(
  parameter int unsigned CLKS_PER_CROTCHET = 12587500,
  parameter int unsigned PHRASE_W          = 2,
  parameter int unsigned CNT_W             = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                restart,
  output logic                crotchet,
  output logic                phrase,
  output logic [2:0]          beat,
  output logic [PHRASE_W-1:0] phrase_idx,
  output logic [6:0]          bass_note,
  output logic                note_load
);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CLKS_PER_CROTCHET - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [PHRASE_W-1:0] PHR_ZERO  = {PHRASE_W{1'b0}};
  localparam logic [PHRASE_W-1:0] PHR_ONE   = PHRASE_W'(1);
  localparam logic [6:0]          NOTE_D3   = 7'd50;

  function automatic logic [6:0] bass_rom(input logic [2:0] idx);
    logic [6:0] note;
    case (idx)
      3'd0:    note = 7'd50;
      3'd1:    note = 7'd45;
      3'd2:    note = 7'd47;
      3'd3:    note = 7'd42;
      3'd4:    note = 7'd43;
      3'd5:    note = 7'd38;
      3'd6:    note = 7'd43;
      3'd7:    note = 7'd45;
      default: note = NOTE_D3;
    endcase
    return note;
  endfunction

  logic [CNT_W-1:0]    cnt_r,        cnt_s;
  logic [2:0]          beat_r,       beat_s;
  logic [PHRASE_W-1:0] phrase_idx_r, phrase_idx_s;
  logic [6:0]          bass_note_r,  bass_note_s;
  logic                crotchet_r,   crotchet_s;
  logic                phrase_r,     phrase_s;
  logic                note_load_r,  note_load_s;

  // Next-state: restart beats a coincident beat event; pause holds everything.
  always_comb begin
    cnt_s        = cnt_r;
    beat_s       = beat_r;
    phrase_idx_s = phrase_idx_r;
    bass_note_s  = bass_note_r;
    crotchet_s   = 1'b0;
    phrase_s     = 1'b0;
    note_load_s  = 1'b0;
    if (restart) begin
      cnt_s        = CNT_ZERO;
      beat_s       = 3'd0;
      phrase_idx_s = PHR_ZERO;
      bass_note_s  = NOTE_D3;
      note_load_s  = 1'b1;
    end else if (run) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s       = CNT_ZERO;
        beat_s      = beat_r + 3'd1;
        bass_note_s = bass_rom(beat_r + 3'd1);
        crotchet_s  = 1'b1;
        note_load_s = 1'b1;
        if (beat_r == 3'd7) begin
          phrase_s     = 1'b1;
          phrase_idx_s = phrase_idx_r + PHR_ONE;
        end else begin
          phrase_s     = 1'b0;
          phrase_idx_s = phrase_idx_r;
        end
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= CNT_ZERO;
      beat_r       <= 3'd0;
      phrase_idx_r <= PHR_ZERO;
      bass_note_r  <= NOTE_D3;
      crotchet_r   <= 1'b0;
      phrase_r     <= 1'b0;
      note_load_r  <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      beat_r       <= beat_s;
      phrase_idx_r <= phrase_idx_s;
      bass_note_r  <= bass_note_s;
      crotchet_r   <= crotchet_s;
      phrase_r     <= phrase_s;
      note_load_r  <= note_load_s;
    end
  end

  assign crotchet   = crotchet_r;
  assign phrase     = phrase_r;
  assign beat       = beat_r;
  assign phrase_idx = phrase_idx_r;
  assign bass_note  = bass_note_r;
  assign note_load  = note_load_r;

endmodule

// File: tb/tb_canon_sequencer.sv
// Randomized scoreboard bench for canon_sequencer: a tick-count reference model
// predicts every cycle's outputs, a separate monitor compares them.
module tb_canon_sequencer;

  localparam int C  = 4;
  localparam int PW = 2;
  localparam int NP = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          restart = 1'b0;
  logic          crotchet, phrase, note_load;
  logic [2:0]    beat;
  logic [PW-1:0] phrase_idx;
  logic [6:0]    bass_note;

  typedef struct {
    logic       crotchet;
    logic       phrase;
    logic       note_load;
    logic [2:0] beat;
    int         phrase_idx;
    logic [6:0] bass_note;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ticks  = 0;
  int   rom [8] = '{50, 45, 47, 42, 43, 38, 43, 45};

  canon_sequencer #(.CLKS_PER_CROTCHET(C), .PHRASE_W(PW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .restart(restart),
    .crotchet(crotchet), .phrase(phrase), .beat(beat),
    .phrase_idx(phrase_idx), .bass_note(bass_note), .note_load(note_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: 'ticks' is the number of running cycles since the last reset/restart.
  task automatic step(input logic r, input logic rs, input logic rn);
    exp_t e;
    @(negedge clk);
    rst = r; restart = rs; run = rn;
    e.crotchet = 1'b0; e.phrase = 1'b0; e.note_load = 1'b0;
    if (r) ticks = 0;
    else if (rs) begin
      ticks = 0;
      e.note_load = 1'b1;
    end else if (rn) begin
      ticks++;
      if (ticks % C == 0) begin
        e.crotchet = 1'b1;
        e.note_load = 1'b1;
      end
    end
    e.beat       = 3'((ticks / C) % 8);
    e.phrase_idx = (ticks / (8 * C)) % NP;
    e.bass_note  = 7'(rom[e.beat]);
    e.phrase     = e.crotchet && (e.beat == 3'd0);
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest prediction after every edge.
  initial begin
    exp_t e;
    logic prev_crotchet = 1'b0;
    logic prev_phrase   = 1'b0;
    logic prev_load     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("crotchet",   int'(crotchet),   int'(e.crotchet));
        check("phrase",     int'(phrase),     int'(e.phrase));
        check("note_load",  int'(note_load),  int'(e.note_load));
        check("beat",       int'(beat),       int'(e.beat));
        check("phrase_idx", int'(phrase_idx), e.phrase_idx);
        check("bass_note",  int'(bass_note),  int'(e.bass_note));
        check("bass_rom_invariant", int'(bass_note), rom[beat]);
        if (phrase) check("phrase_needs_crotchet", int'(crotchet), 1);
        if (prev_crotchet) check("crotchet_width", int'(crotchet), 0);
        if (prev_phrase) check("phrase_width", int'(phrase), 0);
        if (prev_load && !restart) check("note_load_width", int'(note_load), 0);
        prev_crotchet = crotchet;
        prev_phrase   = phrase;
        prev_load     = note_load;
      end
    end
  end

  initial begin
    int guard;
    // Reset for three cycles, then free run through several beats.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (14) step(1'b0, 1'b0, 1'b1);
    // Pause two cycles into a beat for ten cycles, then resume.
    while (ticks % C != 2) step(1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    // Restart colliding with a beat event at beat 5.
    while (!((ticks % C == C - 1) && ((ticks / C) % 8 == 5))) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    // Back-to-back restarts, with run both low and high.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    // Mid-operation reset at beat 6 of phrase 2.
    while (!(((ticks / C) % 8 == 6) && ((ticks / (8 * C)) % NP == 2))) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    // Three full wraps of phrase_idx with run held high.
    repeat (3 * NP * 8 * C) step(1'b0, 1'b0, 1'b1);
    // Random mix of pause, restart and reset.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 128) == 0, ($urandom % 48) == 0, ($urandom % 6) != 0);
    end
    step(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/canon_sequencer.md
Name: canon_sequencer

Overview:
- Tempo and note sequencer for the canon audio/video design; sits directly upstream of the tone synthesiser and the display.
- Divides the system clock into crotchet beats and 8-beat phrases, emitting one-cycle `crotchet` and `phrase` strobes that the display consumes for beat-synchronous animation.
- Steps through the canon ground bass (D A B F# G D G A) and presents the current bass note as a MIDI note number, with a load strobe for the synthesiser.

Parameters:
- CLKS_PER_CROTCHET, 12587500: system clocks per beat (0.5 s at 25.175 MHz); minimum legal value 2.
- PHRASE_W, 2: width of the phrase counter; it wraps every 2^PHRASE_W phrases.
- CNT_W, 24: width of the tempo counter; must satisfy 2^CNT_W > CLKS_PER_CROTCHET.

Ports:
- clk  input  1  system clock (VGA pixel clock).
- rst  input  1  synchronous reset, active-high.
- run  input  1  advance enable; 0 = pause with all state held.
- restart  input  1  one-cycle request to return to beat 0 of phrase 0 without a full reset.
- crotchet  output  1  one-cycle strobe at each beat boundary.
- phrase  output  1  one-cycle strobe at each phrase boundary (beat 7→0); always coincident with `crotchet`.
- beat  output  3  current beat within the phrase, 0..7.
- phrase_idx  output  PHRASE_W  current phrase number.
- bass_note  output  7  MIDI note number of the current bass note.
- note_load  output  1  one-cycle strobe: `bass_note` has just changed.

Behaviour:
- Reset: one clock, synchronous, active-high; all outputs are registered.
- Values on reset:
  - tempo counter = 0, beat = 0, phrase_idx = 0;
  - crotchet = 0, phrase = 0, note_load = 0;
  - bass_note = 50 (D3).
- Bass ROM, indexed by beat 0..7: 50, 45, 47, 42, 43, 38, 43, 45.
  - Combinational lookup; its result is registered into `bass_note`.
  - Invariant: bass_note == ROM[beat] at every cycle.
- Tempo counter:
  - Increments on each cycle where run = 1 and restart = 0.
  - On the cycle it equals CLKS_PER_CROTCHET-1 with run = 1, it wraps to 0 and a beat event occurs.
- Beat event (all registered on the same edge, visible the following cycle):
  - crotchet = 1, note_load = 1;
  - beat = beat+1 mod 8;
  - bass_note = ROM[new beat].
- Phrase boundary: a beat event with beat == 7 additionally sets phrase = 1 and phrase_idx = phrase_idx+1 mod 2^PHRASE_W.
- Strobes:
  - crotchet, phrase and note_load are high for exactly one cycle.
  - They deassert on the next cycle regardless of `run`.
- Timing from reset with run held high: the first crotchet is asserted on clock edge number CLKS_PER_CROTCHET after `rst` deasserts. Spacing between crotchets is exactly CLKS_PER_CROTCHET cycles.
- Pause (run = 0):
  - Tempo counter, beat, phrase_idx and bass_note hold; no strobes are generated.
  - When run returns to 1, counting resumes from the held count; the partial beat is not restarted.
- Restart (restart = 1, sampled on an edge):
  - Sets tempo counter, beat and phrase_idx to 0 and bass_note to 50; effective regardless of `run`.
  - Asserts note_load = 1 for one cycle; crotchet and phrase stay 0.
  - Takes priority over a beat event on the same cycle: that beat event is discarded.
  - Repeated restart cycles re-pulse note_load every cycle.
- rst versus restart: rst has priority over restart and run. A reset mid-beat discards the partial beat; no strobe is emitted on the reset cycle.
- Wrap-around: phrase_idx wraps from 2^PHRASE_W-1 to 0 with a normal phrase strobe; there is no terminal state.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and free run: CLKS_PER_CROTCHET=4, rst high 3 cycles then low, run=1 → crotchet pulses 4, 8, 12 cycles after reset release. beat steps 1, 2, 3; bass_note steps 45, 47, 42; note_load coincident with each crotchet.
- Full phrase: run 32 cycles (CLKS_PER_CROTCHET=4) → the eighth crotchet coincides with phrase=1, beat=0, bass_note=50, phrase_idx=1. After 4 phrases phrase_idx wraps to 0.
- Pause: drop run for 10 cycles two cycles into a beat → no strobes, outputs frozen. Raise run → next crotchet exactly 2 cycles later.
- Restart collision: pulse restart on the same cycle the tempo counter is at 3 (beat 5) → next cycle crotchet=0, phrase=0, note_load=1, beat=0, bass_note=50. Next crotchet 4 cycles after restart.
- Mid-operation reset: assert rst at beat 6, phrase_idx 2 → next cycle all outputs at reset values, bass_note=50, no strobes.
- Scoreboard: 3 full wraps of phrase_idx, checking bass_note==ROM[beat] every cycle, each strobe one cycle wide, and phrase high only when crotchet is high.
